alu_ctrl_fsm: RTL
=================

Name: alu_ctrl_fsm

Overview:
Multi-cycle control unit that drives the datapath ALU from the initiator side of the ALU interface. It fetches one instruction at a time over a valid/req handshake and decodes it. It then sequences the datapath through EXECUTE/MEM/WB, generating the 3-bit ALU control and datapath enables, and consumes the ALU `eq` flag to resolve branches. It sits between instruction memory and the reduced RISC-V datapath (ALU, register file, PC, data memory).

Parameters:
DATA_WIDTH, 32, instruction width; only 32 is supported.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
instr  input  DATA_WIDTH  instruction word from instruction memory.
instr_valid  input  1  instr is valid this cycle.
eq  input  1  ALU equality flag, op1 == op2.
instr_req  output  1  request an instruction; high only in FETCH.
alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or.
alu_src  output  1  0 = ALU op2 from register, 1 = from immediate.
imm_src  output  2  00 I-type, 01 S-type, 10 B-type immediate.
reg_write  output  1  register file write enable (one-cycle pulse).
result_src  output  1  writeback source: 0 = ALU, 1 = data memory.
mem_write  output  1  data memory write enable (one-cycle pulse).
pc_en  output  1  PC update strobe; exactly one pulse per retired instruction.
pc_src  output  1  with pc_en: 0 = PC+4, 1 = PC+branch offset.
illegal  output  1  sticky unsupported-instruction flag.
retired  output  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; latched instruction = 0; retired = 0; illegal = 0.
  - All control outputs 0.
- All outputs are decoded from registered state plus the latched instruction. No combinational path from instr or eq to any output except pc_src in EXECUTE for branches.
- IDLE -> FETCH unconditionally. IDLE is entered only via reset.
- FETCH:
  - instr_req = 1.
  - On a cycle with instr_valid = 1, latch instr and go to DECODE; otherwise stay.
- DECODE: one cycle, no enables asserted. An unsupported encoding sets illegal and goes to TRAP; otherwise go to EXECUTE.
- Supported encodings:
  - R-type, op 0110011: add (f3 000, f7 0000000), sub (f3 000, f7 0100000), and (f3 111, f7 0), or (f3 110, f7 0).
  - I-type ALU, op 0010011: addi (f3 000), andi (f3 111), ori (f3 110).
  - lw: op 0000011, f3 010.
  - sw: op 0100011, f3 010.
  - beq: op 1100011, f3 000. bne: op 1100011, f3 001.
- EXECUTE:
  - alu_ctrl per instruction. lw/sw use add; branches use sub.
  - alu_src = 1 for I-type ALU, lw and sw.
  - imm_src set per format.
  - R-type and I-type ALU go to WB; lw/sw go to MEM.
  - Branch: pc_en = 1; pc_src = eq (beq) or !eq (bne), sampled this cycle; then go to FETCH.
- MEM:
  - sw: mem_write = 1, pc_en = 1, pc_src = 0, then FETCH.
  - lw: no write; go to WB.
- WB:
  - reg_write = 1; pc_en = 1; pc_src = 0.
  - result_src = 1 for lw, else 0.
  - Then FETCH.
- alu_ctrl, alu_src and imm_src hold their EXECUTE values through MEM and WB of the same instruction. In IDLE, FETCH, DECODE and TRAP they are 0.
- retired increments on every pc_en cycle and wraps from 2^CNT_WIDTH-1 to 0.
- Cycle counts from instr_valid acceptance to the pc_en cycle inclusive:
  - branch = 3
  - R/I-type = 4
  - sw = 4
  - lw = 5
- TRAP: terminal state. illegal = 1; all enables and instr_req = 0; only reset exits.
- instr_valid is ignored outside FETCH.
- A reset assertion mid-instruction aborts it immediately: no pc_en, reg_write or mem_write pulse, and retired is cleared.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), instr_valid held high -> instr_req in FETCH. EXECUTE: alu_ctrl=000, alu_src=0. WB: reg_write=1, pc_en=1, pc_src=0. retired=1, 4 cycles after acceptance.
- sub 0x402081B3, then lw 0x0000A183 -> sub: alu_ctrl=001. lw: alu_ctrl=000, alu_src=1, imm_src=00; WB with result_src=1 and reg_write=1; retired=2.
- beq 0x00208463 with eq=1, then bne 0x00209463 with eq=1 -> beq: pc_src=1; bne: pc_src=0. Both with alu_ctrl=001, imm_src=10, pc_en in EXECUTE, no reg_write.
- sw 0x0020A023 with instr_valid delayed 3 cycles -> FETCH holds instr_req=1 throughout. MEM: mem_write=1 for exactly 1 cycle, imm_src=01, no reg_write.
- Illegal word 0x00000000 -> illegal=1 the cycle after DECODE; instr_req stays 0 forever; reset clears it and FETCH resumes.
- CNT_WIDTH=2, retire 5 addi 0x00108093 -> retired sequence 1,2,3,0,1. Assert rst_n low during a WB cycle -> reg_write drops asynchronously and retired=0.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit for the reduced RISC-V datapath: fetches one instruction,
// decodes it and sequences EXECUTE/MEM/WB, driving ALU control and datapath enables.
module alu_ctrl_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  instr_valid,
    input  logic                  eq,
    output logic                  instr_req,
    output logic [2:0]            alu_ctrl,
    output logic                  alu_src,
    output logic [1:0]            imm_src,
    output logic                  reg_write,
    output logic                  result_src,
    output logic                  mem_write,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    // state   | meaning
    // IDLE    | post-reset, moves to FETCH
    // FETCH   | instr_req high, waiting for instr_valid
    // DECODE  | legality check on latched word
    // EXECUTE | ALU operation; branches retire here
    // MEM     | data memory access; sw retires here
    // WB      | register write-back; ALU ops and lw retire here
    // TRAP    | unsupported instruction, exit only by reset
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_TRAP    = 3'd6;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DATA_WIDTH-1:0] ir;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = ir[6:0];
    assign funct3        = ir[14:12];
    assign funct7        = ir[31:25];
    assign unused_fields = ^ir[24:7];

    logic is_add, is_sub, is_and, is_or;
    logic is_addi, is_andi, is_ori;
    logic is_lw, is_sw, is_beq, is_bne, is_br, is_ialu, is_legal;

    assign is_add  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == OP_R) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_and  = (opcode == OP_R) && (funct3 == 3'b111) && (funct7 == 7'b0000000);
    assign is_or   = (opcode == OP_R) && (funct3 == 3'b110) && (funct7 == 7'b0000000);
    assign is_addi = (opcode == OP_I) && (funct3 == 3'b000);
    assign is_andi = (opcode == OP_I) && (funct3 == 3'b111);
    assign is_ori  = (opcode == OP_I) && (funct3 == 3'b110);
    assign is_lw   = (opcode == OP_LW) && (funct3 == 3'b010);
    assign is_sw   = (opcode == OP_SW) && (funct3 == 3'b010);
    assign is_beq  = (opcode == OP_BR) && (funct3 == 3'b000);
    assign is_bne  = (opcode == OP_BR) && (funct3 == 3'b001);
    assign is_br   = is_beq | is_bne;
    assign is_ialu = is_addi | is_andi | is_ori;
    assign is_legal = is_add | is_sub | is_and | is_or | is_ialu | is_lw | is_sw | is_br;

    logic [2:0] dec_alu_ctrl;
    logic       dec_alu_src;
    logic [1:0] dec_imm_src;

    always_comb begin
        dec_alu_ctrl = 3'b000;
        if (is_sub || is_br)
            dec_alu_ctrl = 3'b001;
        else if (is_and || is_andi)
            dec_alu_ctrl = 3'b010;
        else if (is_or || is_ori)
            dec_alu_ctrl = 3'b011;
    end

    assign dec_alu_src = is_ialu | is_lw | is_sw;
    assign dec_imm_src = is_sw ? 2'b01 : (is_br ? 2'b10 : 2'b00);

    logic in_exec, in_mem, in_wb, active;
    assign in_exec = (state == S_EXECUTE);
    assign in_mem  = (state == S_MEM);
    assign in_wb   = (state == S_WB);
    assign active  = in_exec | in_mem | in_wb;

    // ALU selects hold their EXECUTE value until the instruction retires
    assign alu_ctrl   = active ? dec_alu_ctrl : 3'b000;
    assign alu_src    = active & dec_alu_src;
    assign imm_src    = active ? dec_imm_src : 2'b00;
    assign instr_req  = (state == S_FETCH);
    assign reg_write  = in_wb;
    assign result_src = in_wb & is_lw;
    assign mem_write  = in_mem & is_sw;
    assign pc_en      = (in_exec & is_br) | (in_mem & is_sw) | in_wb;
    // eq is the only input allowed to reach an output combinationally
    assign pc_src     = in_exec & ((is_beq & eq) | (is_bne & ~eq));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_FETCH;
            S_FETCH:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE:  state_nxt = is_legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (is_br)
                    state_nxt = S_FETCH;
                else if (is_lw || is_sw)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM:     state_nxt = is_sw ? S_FETCH : S_WB;
            S_WB:      state_nxt = S_FETCH;
            S_TRAP:    state_nxt = S_TRAP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_FETCH) && instr_valid)
                ir <= instr;
            if ((state == S_DECODE) && !is_legal)
                illegal <= 1'b1;
            if (pc_en)
                retired <= retired + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule
